mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares the single unified memory port between instruction fetch (IF stage) and the load/store path (MEM stage, driven by the decoded MemRead/MemWrite).
- Serialises requests with a small FSM, registers the address, write data and byte strobes for the whole transaction, and returns read data with a one-cycle ready pulse.
- Generates the stall signals that freeze the pipeline while an access is outstanding.
- Round-robin tie-break prevents fetch starvation during back-to-back loads and stores.

Parameters:
ADDR_W, 32, address width of both requesters and the memory port
DATA_W, 32, data width; strobe width is DATA_W/8

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
if_req  input  1  fetch request; held high until if_ready
if_addr  input  ADDR_W  fetch address (PC)
if_rdata  output  DATA_W  fetched instruction, valid while if_ready=1
if_ready  output  1  one-cycle pulse: fetch complete
d_read  input  1  load request (MemRead); held until d_ready
d_write  input  1  store request (MemWrite); held until d_ready
d_addr  input  ADDR_W  load/store address (ALU result)
d_wdata  input  DATA_W  store data
d_wstrb  input  DATA_W/8  store byte enables
d_rdata  output  DATA_W  load data, valid while d_ready=1
d_ready  output  1  one-cycle pulse: load/store complete
mem_req  output  1  memory request, high for the whole transaction
mem_we  output  1  1 = write
mem_addr  output  ADDR_W  registered address
mem_wdata  output  DATA_W  registered write data
mem_wstrb  output  DATA_W/8  registered strobes; all zero on reads
mem_rdata  input  DATA_W  memory read data, valid with mem_ack
mem_ack  input  1  memory completes the current transaction this cycle
stall_if  output  1  freeze PC and IF/ID
stall_mem  output  1  freeze EX/MEM and all earlier stages

Behaviour:
- Reset (async, rst_n=0), taking effect immediately:
  - state=IDLE, last_grant=FETCH.
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_wstrb=0.
  - if_ready=0, d_ready=0, if_rdata=0, d_rdata=0.
  - Any in-flight transaction is abandoned with no ready pulse. A mem_ack arriving after reset release while in IDLE is ignored.
- States: IDLE, BUSY_IF, BUSY_D.
- Effective requests:
  - dv = (d_read|d_write) & ~d_ready
  - iv = if_req & ~if_ready
  - Masking with the ready pulse stops a requester from being re-granted in the cycle it is being released.
- IDLE transitions:
  - dv only: grant data → BUSY_D.
  - iv only: grant fetch → BUSY_IF.
  - Both: grant the requester that is NOT last_grant. After reset data wins.
  - Neither: stay in IDLE.
- On grant, the same edge loads:
  - mem_addr ← chosen address.
  - For data: mem_we ← d_write, mem_wdata ← d_wdata, mem_wstrb ← d_write ? d_wstrb : 0.
  - For fetch: mem_we ← 0, mem_wstrb ← 0.
  - last_grant ← chosen requester.
- d_read & d_write both high is illegal; it is treated as a write.
- mem_req = (state != IDLE). Port outputs stay constant throughout BUSY; requester input changes are ignored.
- In BUSY_x with mem_ack=1, the same edge does:
  - state → IDLE.
  - x_ready ← 1 for exactly one cycle.
  - x_rdata ← mem_rdata on reads; x_rdata is unchanged on writes.
- Without mem_ack, the FSM stays in BUSY indefinitely (no timeout).
- Latency:
  - Request seen in IDLE at cycle 0 → mem_req from cycle 1.
  - mem_ack at cycle k≥1 → ready at cycle k+1.
  - Minimum 2 cycles.
  - Always one IDLE cycle between transactions. This is the ready cycle, and a new grant may occur in it.
- if_rdata/d_rdata hold their last value outside ready pulses.
- Stalls (combinational):
  - stall_mem = dv.
  - stall_if = iv | dv.
  - Both are low in the cycle the respective ready is high, so the pipeline advances exactly once per completion.

Test Plan:
1. Reset, then if_req=1 at if_addr=0x0000_0010, mem_ack one cycle after mem_req rises, mem_rdata=0x0000_0093 → mem_req/mem_we=0/mem_addr=0x10 in cycle 1, if_ready=1 with if_rdata=0x93 in cycle 3, stall_if high cycles 0–2.
2. d_write, d_addr=0x100, d_wdata=0xDEADBEEF, d_wstrb=4'b0011, ack after 3 wait cycles → mem_we=1, mem_wstrb=0011 stable for 4 cycles, single d_ready pulse, d_rdata unchanged, stall_mem high until the ready cycle.
3. if_req and d_read asserted together right after reset → data granted first. Fetch is granted in the d_ready cycle; next tie goes to data again (alternation verified over 4 transactions of back-to-back loads).
4. d_addr changed to 0x200 while BUSY_D with address 0x100 → mem_addr stays 0x100 until ack.
5. rst_n pulled low in BUSY_IF before mem_ack → mem_req=0 immediately, no if_ready. After release, a stray mem_ack in IDLE produces no ready pulse.
6. d_read and d_write both high, d_wstrb=4'b1111 → transaction issued as write with mem_we=1, mem_wstrb=1111.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - arbiter sharing one memory port between instruction fetch and load/store
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_ready,
  input  logic                d_read,
  input  logic                d_write,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_wstrb,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_ready,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ack,
  output logic                stall_if,
  output logic                stall_mem
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] BUSY_IF = 2'd1;
  localparam logic [1:0] BUSY_D  = 2'd2;

  localparam logic GRANT_FETCH = 1'b0;
  localparam logic GRANT_DATA  = 1'b1;

  logic [1:0] state;
  logic       last_grant;
  logic       dv;
  logic       iv;
  logic       pick_d;
  logic       pick_i;

  // A requester being released this cycle must not be granted again on the same edge.
  assign dv = (d_read | d_write) & ~d_ready;
  assign iv = if_req & ~if_ready;

  // On a tie the requester that did not win last time goes first.
  assign pick_d = dv & (~iv | (last_grant == GRANT_FETCH));
  assign pick_i = iv & ~pick_d;

  assign mem_req   = (state != IDLE);
  assign stall_mem = dv;
  assign stall_if  = iv | dv;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= GRANT_FETCH;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_wstrb  <= '0;
      if_ready   <= 1'b0;
      d_ready    <= 1'b0;
      if_rdata   <= '0;
      d_rdata    <= '0;
    end else begin
      if_ready <= 1'b0;
      d_ready  <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_d) begin
            state      <= BUSY_D;
            last_grant <= GRANT_DATA;
            mem_addr   <= d_addr;
            mem_we     <= d_write;
            mem_wdata  <= d_wdata;
            mem_wstrb  <= d_write ? d_wstrb : '0;
          end else if (pick_i) begin
            state      <= BUSY_IF;
            last_grant <= GRANT_FETCH;
            mem_addr   <= if_addr;
            mem_we     <= 1'b0;
            mem_wstrb  <= '0;
          end
        end
        BUSY_IF: begin
          if (mem_ack) begin
            state    <= IDLE;
            if_ready <= 1'b1;
            if_rdata <= mem_rdata;
          end
        end
        BUSY_D: begin
          if (mem_ack) begin
            state   <= IDLE;
            d_ready <= 1'b1;
            if (!mem_we) begin
              d_rdata <= mem_rdata;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
